apb_pad_ctrl: RTL and testbench

- Parametrised APB slave that controls the pad frame: a mux select and a pad config (pull, Schmitt trigger, slew, drive) for each pad.
- Software writes to shadow registers. A COMMIT then transfers them to the active outputs atomically, through a settle sequence.
- During the settle sequence, every pad whose mux select changes is held at a safe config for SETTLE_CYCLES cycles before the new mux/cfg take effect, so no pad glitches onto a new function.
- Also provides a sticky lock, error reporting and an info register. Sits on the peripheral APB bus, directly driving the pad frame.

---
 rtl/apb_pad_ctrl_pkg.sv | 25 ++
 rtl/apb_pad_ctrl_seq.sv | 55 +++++
 rtl/apb_pad_ctrl.sv | 178 +++++++++++++++++
 tb/tb_apb_pad_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pad_ctrl_pkg.sv
// Shared constants and types for the pad-frame controller.
package apb_pad_ctrl_pkg;

  // Register offsets (bytes) and per-pad region bases
  localparam logic [9:0] OFF_CTRL   = 10'h000;
  localparam logic [9:0] OFF_STATUS = 10'h004;
  localparam logic [9:0] OFF_INFO   = 10'h008;
  localparam logic [9:0] BASE_MUX   = 10'h100;
  localparam logic [9:0] BASE_CFG   = 10'h200;
  localparam logic [9:0] BASE_ACT   = 10'h300;

  // CTRL bits
  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_LOCK   = 1;

  // STATUS bits
  localparam int STAT_BUSY   = 0;
  localparam int STAT_LOCKED = 1;
  localparam int STAT_ERR    = 2;

  localparam logic [3:0] VERSION = 4'd2;

  typedef enum logic {IDLE, SETTLE} state_t;

endpackage

// File: rtl/apb_pad_ctrl_seq.sv
// Commit sequencer: captures which pads change function, holds them at the
// safe config for SETTLE_CYCLES cycles, then pulses load_o.
module apb_pad_ctrl_seq
  import apb_pad_ctrl_pkg::*;
#(
  parameter int unsigned N_PADS        = 32,
  parameter int unsigned MUX_WIDTH     = 2,
  parameter int unsigned SETTLE_CYCLES = 4
)(
  input  logic                                HCLK,
  input  logic                                HRESETn,
  input  logic                                commit_i,
  input  logic [N_PADS-1:0][MUX_WIDTH-1:0]    shadow_mux,
  input  logic [N_PADS-1:0][MUX_WIDTH-1:0]    active_mux,
  output logic                                load_o,
  output logic                                busy_o,
  output logic [N_PADS-1:0]                   force_mask_o
);

  state_t            state;
  logic [7:0]        cnt;
  logic [N_PADS-1:0] chg_mask;

  // Commit FSM: IDLE -> SETTLE on commit, back to IDLE when the count expires
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      cnt      <= '0;
      chg_mask <= '0;
      busy_o   <= 1'b0;
    end else if (state == IDLE) begin
      if (commit_i && (SETTLE_CYCLES != 0)) begin
        state  <= SETTLE;
        cnt    <= 8'(SETTLE_CYCLES - 1);
        busy_o <= 1'b1;
        for (int i = 0; i < N_PADS; i++)
          chg_mask[i] <= (shadow_mux[i] != active_mux[i]);
      end
    end else begin
      if (cnt == 8'd0) begin
        state    <= IDLE;
        busy_o   <= 1'b0;
        chg_mask <= '0;
      end else begin
        cnt <= cnt - 8'd1;
      end
    end
  end

  // With no settle time the transfer happens on the commit edge itself
  assign load_o       = (SETTLE_CYCLES == 0) ? commit_i
                                             : ((state == SETTLE) && (cnt == 8'd0));
  assign force_mask_o = chg_mask;

endmodule

// File: rtl/apb_pad_ctrl.sv
// APB slave for the pad frame: shadow mux/cfg registers, atomic commit with
// glitch-free settle, sticky lock and error reporting.
module apb_pad_ctrl
  import apb_pad_ctrl_pkg::*;
#(
  parameter int unsigned          APB_ADDR_WIDTH = 12,
  parameter int unsigned          N_PADS         = 32,
  parameter int unsigned          MUX_WIDTH      = 2,
  parameter int unsigned          CFG_WIDTH      = 6,
  parameter int unsigned          SETTLE_CYCLES  = 4,
  parameter logic [CFG_WIDTH-1:0] SAFE_CFG       = '0
)(
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0]        PADDR,
  input  logic [31:0]                      PWDATA,
  input  logic                             PWRITE,
  input  logic                             PSEL,
  input  logic                             PENABLE,
  output logic [31:0]                      PRDATA,
  output logic                             PREADY,
  output logic                             PSLVERR,
  output logic [N_PADS-1:0][MUX_WIDTH-1:0] pad_mux_o,
  output logic [N_PADS-1:0][CFG_WIDTH-1:0] pad_cfg_o,
  output logic                             busy_o
);

  logic [N_PADS-1:0][MUX_WIDTH-1:0] shadow_mux, active_mux;
  logic [N_PADS-1:0][CFG_WIDTH-1:0] shadow_cfg, active_cfg;
  logic                             locked, err_q;
  logic                             load, busy;
  logic [N_PADS-1:0]                force_mask;

  // Address decode: only PADDR[9:2] matters
  logic [9:0] off;
  logic [1:0] region;
  logic [5:0] pad_idx;
  logic       unused_bits;

  assign off         = {PADDR[9:2], 2'b00};
  assign region      = off[9:8];
  assign pad_idx     = off[7:2];
  assign unused_bits = ^{PADDR, PWDATA};

  logic access, is_ctrl, is_status, is_info, is_mux, is_cfg, is_act;
  logic in_range, addr_err, wr_err, err, wr_ok, commit;

  assign access    = PSEL & PENABLE;
  assign is_ctrl   = (off == OFF_CTRL);
  assign is_status = (off == OFF_STATUS);
  assign is_info   = (off == OFF_INFO);
  assign is_mux    = (region == BASE_MUX[9:8]);
  assign is_cfg    = (region == BASE_CFG[9:8]);
  assign is_act    = (region == BASE_ACT[9:8]);
  assign in_range  = ({1'b0, pad_idx} < 7'(N_PADS));

  assign addr_err = (region == 2'b00) ? !(is_ctrl | is_status | is_info) : !in_range;

  // Once locked only the ERR clear is allowed; while busy the shadows and
  // COMMIT are frozen so the in-flight transfer stays atomic.
  assign wr_err = PWRITE & (locked ? !is_status
                                   : (busy & (is_mux | is_cfg | (is_ctrl & PWDATA[CTRL_COMMIT]))));
  assign err    = addr_err | wr_err;
  assign wr_ok  = access & PWRITE & ~err;
  assign commit = wr_ok & is_ctrl & PWDATA[CTRL_COMMIT];

  apb_pad_ctrl_seq #(
    .N_PADS        (N_PADS),
    .MUX_WIDTH     (MUX_WIDTH),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_seq (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .commit_i     (commit),
    .shadow_mux   (shadow_mux),
    .active_mux   (active_mux),
    .load_o       (load),
    .busy_o       (busy),
    .force_mask_o (force_mask)
  );

  // Shadow registers take APB writes; active registers copy shadow on load
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      shadow_mux <= '0;
      shadow_cfg <= '0;
      active_mux <= '0;
      active_cfg <= '0;
    end else begin
      for (int i = 0; i < N_PADS; i++) begin
        if (wr_ok && is_mux && (pad_idx == 6'(i)))
          shadow_mux[i] <= PWDATA[MUX_WIDTH-1:0];
        if (wr_ok && is_cfg && (pad_idx == 6'(i)))
          shadow_cfg[i] <= PWDATA[CFG_WIDTH-1:0];
      end
      if (load) begin
        active_mux <= shadow_mux;
        active_cfg <= shadow_cfg;
      end
    end
  end

  // Sticky lock and error flag
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      locked <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (wr_ok && is_ctrl && PWDATA[CTRL_LOCK])
        locked <= 1'b1;
      if (access && err)
        err_q <= 1'b1;
      else if (wr_ok && is_status && PWDATA[STAT_ERR])
        err_q <= 1'b0;
    end
  end

  // Per-pad read selection; an out-of-range index matches nothing
  logic [MUX_WIDTH-1:0] rd_smux, rd_amux;
  logic [CFG_WIDTH-1:0] rd_scfg, rd_acfg;

  always_comb begin
    rd_smux = '0;
    rd_amux = '0;
    rd_scfg = '0;
    rd_acfg = '0;
    for (int i = 0; i < N_PADS; i++) begin
      if (pad_idx == 6'(i)) begin
        rd_smux = shadow_mux[i];
        rd_amux = active_mux[i];
        rd_scfg = shadow_cfg[i];
        rd_acfg = active_cfg[i];
      end
    end
  end

  // Read data mux
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (region == 2'b00) begin
      if (is_ctrl) begin
        rdata[CTRL_LOCK] = locked;
      end else if (is_status) begin
        rdata[STAT_BUSY]   = busy;
        rdata[STAT_LOCKED] = locked;
        rdata[STAT_ERR]    = err_q;
      end else if (is_info) begin
        rdata[7:0]   = 8'(N_PADS);
        rdata[11:8]  = 4'(MUX_WIDTH);
        rdata[15:12] = 4'(CFG_WIDTH - 1);
        rdata[19:16] = VERSION;
      end
    end else if (is_mux) begin
      rdata[MUX_WIDTH-1:0] = rd_smux;
    end else if (is_cfg) begin
      rdata[CFG_WIDTH-1:0] = rd_scfg;
    end else if (is_act) begin
      rdata[8 +: CFG_WIDTH] = rd_acfg;
      rdata[MUX_WIDTH-1:0]  = rd_amux;
    end
  end

  assign PRDATA  = (access & ~PWRITE & ~err) ? rdata : 32'h0;
  assign PSLVERR = access & err;
  assign PREADY  = 1'b1;

  // Changing pads sit at the safe config while the sequencer settles
  always_comb begin
    for (int i = 0; i < N_PADS; i++)
      pad_cfg_o[i] = force_mask[i] ? SAFE_CFG : active_cfg[i];
  end

  assign pad_mux_o = active_mux;
  assign busy_o    = busy;

endmodule

// File: tb/tb_apb_pad_ctrl.sv
// Randomized bench for apb_pad_ctrl with an abstract reference model, plus
// a second instance exercising the zero-settle / 64-pad configuration.
module tb_apb_pad_ctrl;

  localparam int N   = 32;
  localparam int MW  = 2;
  localparam int CW  = 6;
  localparam int S   = 4;
  localparam int N1  = 64;
  localparam int MW1 = 3;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0, PENABLE = 1'b0, psel0 = 1'b0, psel1 = 1'b0;

  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1, busy0, busy1;
  logic [N-1:0][MW-1:0]   mux0;
  logic [N-1:0][CW-1:0]   cfg0;
  logic [N1-1:0][MW1-1:0] mux1;
  logic [N1-1:0][CW-1:0]  cfg1;

  int errors = 0;
  int checks = 0;
  bit b1_seen = 1'b0;

  always #5 HCLK = ~HCLK;

  apb_pad_ctrl u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(psel0), .PENABLE(PENABLE), .PRDATA(prdata0),
    .PREADY(pready0), .PSLVERR(pslverr0), .pad_mux_o(mux0),
    .pad_cfg_o(cfg0), .busy_o(busy0)
  );

  apb_pad_ctrl #(.N_PADS(N1), .MUX_WIDTH(MW1), .SETTLE_CYCLES(0)) u_dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(psel1), .PENABLE(PENABLE), .PRDATA(prdata1),
    .PREADY(pready1), .PSLVERR(pslverr1), .pad_mux_o(mux1),
    .pad_cfg_o(cfg1), .busy_o(busy1)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (dut0) ----------------
  int m_smux[N], m_scfg[N], m_amux[N], m_acfg[N];
  bit m_force[N];
  int m_left;          // settle cycles still to run; busy while > 0
  bit m_lock, m_err;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_smux[i] = 0; m_scfg[i] = 0; m_amux[i] = 0; m_acfg[i] = 0; m_force[i] = 0;
    end
    m_left = 0; m_lock = 0; m_err = 0;
  endfunction

  // Response of the register file to one access, from current model state
  function automatic void resp(input int addr, input bit wr, input int wd,
                               output bit e, output int rd);
    int off, rg, idx;
    off = addr & 'h3FC;
    rg  = off >> 8;
    idx = (off & 'hFF) >> 2;
    e = 0; rd = 0;
    if (rg == 0) begin
      if (idx > 2) e = 1;
      else if (wr) begin
        if (m_lock && idx != 1) e = 1;
        else if (idx == 0 && (wd & 1) != 0 && m_left > 0) e = 1;
      end else begin
        case (idx)
          0: rd = int'(m_lock) << 1;
          1: rd = int'(m_left > 0) | (int'(m_lock) << 1) | (int'(m_err) << 2);
          default: rd = N | (MW << 8) | ((CW - 1) << 12) | (2 << 16);
        endcase
      end
    end else begin
      if (idx >= N) e = 1;
      else if (wr) begin
        if (m_lock) e = 1;
        else if (rg != 3 && m_left > 0) e = 1;
      end else begin
        if (rg == 1)      rd = m_smux[idx];
        else if (rg == 2) rd = m_scfg[idx];
        else              rd = (m_acfg[idx] << 8) | m_amux[idx];
      end
    end
  endfunction

  task automatic m_load();
    for (int i = 0; i < N; i++) begin
      m_amux[i] = m_smux[i]; m_acfg[i] = m_scfg[i]; m_force[i] = 0;
    end
  endtask

  task automatic m_step();
    bit e;
    int rd, off, rg, idx;
    bit do_commit;
    do_commit = 0;
    if (psel0 && PENABLE) begin
      resp(int'(PADDR), PWRITE, int'(PWDATA), e, rd);
      off = int'(PADDR) & 'h3FC;
      rg  = off >> 8;
      idx = (off & 'hFF) >> 2;
      if (e) m_err = 1;
      else if (PWRITE) begin
        if (rg == 0 && idx == 0) begin
          do_commit = PWDATA[0];
          if (PWDATA[1]) m_lock = 1;
        end else if (rg == 0 && idx == 1) begin
          if (PWDATA[2]) m_err = 0;
        end else if (rg == 1) m_smux[idx] = int'(PWDATA[MW-1:0]);
        else if (rg == 2)     m_scfg[idx] = int'(PWDATA[CW-1:0]);
      end
    end
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_load();
    end
    if (do_commit) begin
      if (S == 0) m_load();
      else begin
        for (int i = 0; i < N; i++) m_force[i] = (m_smux[i] != m_amux[i]);
        m_left = S;
      end
    end
  endtask

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) m_reset();
    else m_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge HCLK) begin
    logic [N-1:0][MW-1:0] em;
    logic [N-1:0][CW-1:0] ec;
    bit e;
    int rd;
    for (int i = 0; i < N; i++) begin
      em[i] = MW'(m_amux[i]);
      ec[i] = m_force[i] ? CW'(0) : CW'(m_acfg[i]);
    end
    chk("pad_mux_o", 256'(mux0), 256'(em));
    chk("pad_cfg_o", 256'(cfg0), 256'(ec));
    chk("busy_o", 256'(busy0), 256'(m_left > 0));
    chk("PREADY", 256'(pready0 & pready1), 256'(1));
    if (psel0 && PENABLE) begin
      resp(int'(PADDR), PWRITE, int'(PWDATA), e, rd);
      chk("PSLVERR", 256'(pslverr0), 256'(e));
      if (!PWRITE) chk("PRDATA", 256'(prdata0), 256'(32'(rd)));
    end else begin
      chk("PSLVERR_idle", 256'(pslverr0), 256'(0));
      chk("PRDATA_idle", 256'(prdata0), 256'(0));
    end
    if (busy1) b1_seen = 1'b1;
  end

  // One APB transfer (setup + access); returns just after the access edge
  task automatic apb(input bit which, input int addr, input bit wr, input int wd,
                     output int rd, output bit e);
    @(posedge HCLK); #1;
    PADDR = 12'(addr); PWRITE = wr; PWDATA = 32'(wd);
    psel0 = !which; psel1 = which; PENABLE = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(negedge HCLK);
    rd = which ? int'(prdata1) : int'(prdata0);
    e  = which ? pslverr1 : pslverr0;
    @(posedge HCLK); #1;
    psel0 = 1'b0; psel1 = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rd;
    bit e;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    // Reset in the middle of a settle
    apb(0, 'h104, 1, 1, rd, e);
    apb(0, 'h000, 1, 1, rd, e);
    chk("t1_busy_after_commit", 256'(busy0), 256'(1));
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b0;
    @(negedge HCLK);
    chk("t1_busy_in_reset", 256'(busy0), 256'(0));
    chk("t1_mux_in_reset", 256'(mux0), 256'(0));
    chk("t1_cfg_in_reset", 256'(cfg0), 256'(0));
    @(posedge HCLK); #1 HRESETn = 1'b1;
    apb(0, 'h004, 0, 0, rd, e);
    chk("t1_status", 256'(32'(rd)), 256'(0));

    // Commit with no mux change: full settle, nothing forced
    apb(0, 'h20C, 1, 'h3, rd, e);
    apb(0, 'h21C, 1, 'h2A, rd, e);
    apb(0, 'h000, 1, 1, rd, e);
    chk("t2a_busy", 256'(busy0), 256'(1));
    chk("t2a_cfg3_old", 256'(cfg0[3]), 256'(0));
    repeat (4) @(posedge HCLK);
    #1;
    chk("t2a_busy_done", 256'(busy0), 256'(0));
    chk("t2a_cfg3_new", 256'(cfg0[3]), 256'(3));
    chk("t2a_cfg7_new", 256'(cfg0[7]), 256'('h2A));

    // Mux change on pad 3: safe config for 4 cycles, pad 7 untouched
    apb(0, 'h10C, 1, 2, rd, e);
    apb(0, 'h20C, 1, 'h11, rd, e);
    apb(0, 'h000, 1, 1, rd, e);
    chk("t2b_cfg3_safe", 256'(cfg0[3]), 256'(0));
    chk("t2b_cfg7_keep", 256'(cfg0[7]), 256'('h2A));
    chk("t2b_mux3_old", 256'(mux0[3]), 256'(0));
    repeat (3) @(posedge HCLK);
    #1;
    chk("t2b_busy_last", 256'(busy0), 256'(1));
    chk("t2b_cfg3_safe_last", 256'(cfg0[3]), 256'(0));
    @(posedge HCLK); #1;
    chk("t2b_mux3_new", 256'(mux0[3]), 256'(2));
    chk("t2b_cfg3_new", 256'(cfg0[3]), 256'('h11));
    chk("t2b_busy_done", 256'(busy0), 256'(0));

    // Errors
    apb(0, 'h000, 1, 1, rd, e);
    apb(0, 'h114, 1, 3, rd, e);
    chk("t3_busy_wr_err", 256'(e), 256'(1));
    apb(0, 'h114, 0, 0, rd, e);
    chk("t3_mux5_unchanged", 256'(32'(rd)), 256'(0));
    apb(0, 'h004, 0, 0, rd, e);
    chk("t3_err_set", 256'(32'(rd)), 256'(4));
    apb(0, 'h004, 1, 4, rd, e);
    apb(0, 'h004, 0, 0, rd, e);
    chk("t3_err_clr", 256'(32'(rd)), 256'(0));
    apb(0, 'h1A0, 0, 0, rd, e);
    chk("t3_oor_err", 256'(e), 256'(1));
    chk("t3_oor_data", 256'(32'(rd)), 256'(0));
    apb(0, 'h008, 0, 0, rd, e);
    chk("t3_info", 256'(32'(rd)), 256'(32'h0002_5220));

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      int sel, idx, hi;
      sel = int'($urandom_range(0, 9));
      idx = int'($urandom_range(0, 39));
      hi  = int'($urandom_range(0, 3)) << 10;
      case (sel)
        0, 1: apb(0, hi | ('h100 + 4 * idx), 1, int'($urandom), rd, e);
        2, 3: apb(0, hi | ('h200 + 4 * idx), 1, int'($urandom), rd, e);
        4:    apb(0, hi, 1, 1, rd, e);
        5:    apb(0, 'h004, 1, int'($urandom) & 4, rd, e);
        6:    apb(0, hi | ('h100 * int'($urandom_range(1, 3)) + 4 * idx), 0, 0, rd, e);
        7:    apb(0, hi | (4 * int'($urandom_range(0, 63))), 0, 0, rd, e);
        8:    apb(0, ($urandom_range(0, 1) != 0) ? ('h300 + 4 * idx) : (4 * int'($urandom_range(2, 63))),
                  1, int'($urandom), rd, e);
        default: repeat ($urandom_range(0, 5)) @(posedge HCLK);
      endcase
    end

    // COMMIT together with LOCK is accepted, then lock holds
    do_reset();
    apb(0, 'h108, 1, 1, rd, e);
    apb(0, 'h000, 1, 3, rd, e);
    chk("t4_commit_lock_ok", 256'(e), 256'(0));
    chk("t4_commit_lock_busy", 256'(busy0), 256'(1));
    repeat (4) @(posedge HCLK);
    #1;
    chk("t4_mux2", 256'(mux0[2]), 256'(1));
    apb(0, 'h200, 1, 'h3F, rd, e);
    chk("t4_locked_wr_err", 256'(e), 256'(1));
    apb(0, 'h200, 0, 0, rd, e);
    chk("t4_cfg0_unchanged", 256'(32'(rd)), 256'(0));
    apb(0, 'h000, 1, 1, rd, e);
    chk("t4_locked_commit_err", 256'(e), 256'(1));
    @(negedge HCLK);
    chk("t4_no_busy", 256'(busy0), 256'(0));
    apb(0, 'h004, 0, 0, rd, e);
    chk("t4_status_locked_err", 256'(32'(rd)), 256'(6));
    apb(0, 'h004, 1, 4, rd, e);
    chk("t4_w1c_allowed", 256'(e), 256'(0));
    do_reset();
    apb(0, 'h004, 0, 0, rd, e);
    chk("t4_reset_unlocks", 256'(32'(rd)), 256'(0));

    // Zero-settle, 64-pad, 3-bit mux instance
    apb(1, 'h1FC, 1, 5, rd, e);
    apb(1, 'h000, 1, 1, rd, e);
    chk("t5_mux63", 256'(mux1[63]), 256'(5));
    apb(1, 'h008, 0, 0, rd, e);
    chk("t5_info", 256'(32'(rd)), 256'(32'h0002_5340));
    apb(1, 'h3FC, 0, 0, rd, e);
    chk("t5_act63", 256'(32'(rd)), 256'(5));
    repeat (2) @(posedge HCLK);
    chk("t5_busy_never", 256'(b1_seen), 256'(0));
    chk("t5_cfg1", 256'(cfg1), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
